// File: rtl/mem_burst_pkg.sv
// mem_burst_pkg
//   Shared definitions for the burst master: FSM state encoding, default
//   interface widths and the depth of the read-return buffer.
package mem_burst_pkg;

  localparam int ADDR_WIDTH_DEF = 9;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int LEN_WIDTH_DEF  = 8;
  localparam int RBUF_DEPTH     = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/mem_burst_rbuf.sv
// mem_burst_rbuf
//   Two-entry synchronous FIFO that absorbs read words returning from the RAM.
//   Ports:
//     clk_i, rst_ni   clock, asynchronous active-low reset
//     push_i/data_i   write one word (ignored when full and not popping)
//     pop_i           remove the head word (ignored when empty)
//     head_o          current head word, held stable until popped
//     count_o         number of stored words (0..2)
module mem_burst_rbuf
  import mem_burst_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [1:0]            count_o
);

  logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
  logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  pop_ok_s;
  logic                  push_ok_s;

  // Next-state computation for storage, pointers and occupancy.
  always_comb begin
    ent0_d   = ent0_q;
    ent1_d   = ent1_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    pop_ok_s  = pop_i && (count_q != 2'd0);
    push_ok_s = push_i && ((count_q != 2'd2) || pop_ok_s);

    if (push_ok_s) begin
      if (wr_ptr_q == 1'b0) begin
        ent0_d = data_i;
      end else begin
        ent1_d = data_i;
      end
      wr_ptr_d = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_ok_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent0_q   <= '0;
      ent1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      ent0_q   <= ent0_d;
      ent1_q   <= ent1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = rd_ptr_q ? ent1_q : ent0_q;
  assign count_o = count_q;

endmodule

// File: rtl/mem_burst_master.sv
// mem_burst_master
//   Initiator for a single-port synchronous RAM. Accepts burst commands,
//   drives per-beat RAM strobes and returns read data as a valid/ready
//   stream. Read issue is throttled so buffered plus in-flight words never
//   exceed the 2-entry return buffer.
//   Ports:
//     clk_i, rst_ni                 clock, asynchronous active-low reset
//     cmd_*                         burst command (we, start addr, beats-1)
//     wdata_valid_i/ready_o/wdata_i write beat stream
//     rdata_valid_o/ready_i/rdata_o read beat stream
//     done_o                        one-cycle pulse after a burst completes
//     busy_o                        high while a burst is in progress
//     ram_*                         RAM strobes; ram_rdata_i is valid the
//                                   cycle after ram_re_o
module mem_burst_master
  import mem_burst_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic                  wdata_valid_i,
  output logic                  wdata_ready_o,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rdata_valid_o,
  input  logic                  rdata_ready_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic                  ram_re_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  inflight_q, inflight_d;

  logic [1:0]            rbuf_count_s;
  logic [DATA_WIDTH-1:0] rbuf_head_s;
  logic                  pop_s;
  logic [2:0]            occ_s;

  // The RAM word requested last cycle is pushed straight into the buffer.
  mem_burst_rbuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rbuf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (inflight_q),
    .data_i  (ram_rdata_i),
    .pop_i   (pop_s),
    .head_o  (rbuf_head_s),
    .count_o (rbuf_count_s)
  );

  assign pop_s = (rbuf_count_s != 2'd0) && rdata_ready_i;

  // Buffer slots that will still be claimed after this cycle's pop; an issue
  // is allowed only while this is below the buffer depth, so a 1-beat/cycle
  // stream is sustained but the returning word always finds a free slot.
  assign occ_s = {1'b0, rbuf_count_s} + {2'b00, inflight_q} - {2'b00, pop_s};

  // Next-state, RAM strobe and handshake logic.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    done_d        = 1'b0;
    cmd_ready_o   = 1'b0;
    wdata_ready_o = 1'b0;
    ram_re_o      = 1'b0;
    ram_we_o      = 1'b0;
    ram_addr_o    = '0;
    ram_wdata_o   = '0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          addr_d  = cmd_addr_i;
          cnt_d   = cmd_len_i;
          state_d = cmd_we_i ? ST_WRITE : ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WRITE: begin
        wdata_ready_o = 1'b1;
        if (wdata_valid_i) begin
          ram_we_o    = 1'b1;
          ram_addr_o  = addr_q;
          ram_wdata_o = wdata_i;
          addr_d      = addr_q + ADDR_WIDTH'(1);
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - LEN_WIDTH'(1);
          end
        end else begin
          state_d = ST_WRITE;
        end
      end

      ST_READ: begin
        if (occ_s < 3'(RBUF_DEPTH)) begin
          ram_re_o   = 1'b1;
          ram_addr_o = addr_q;
          addr_d     = addr_q + ADDR_WIDTH'(1);
          if (cnt_q == '0) begin
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q - LEN_WIDTH'(1);
          end
        end else begin
          state_d = ST_READ;
        end
      end

      ST_DRAIN: begin
        // Leave as soon as the buffer empties with this cycle's pop.
        if (occ_s == 3'd0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    inflight_d = ram_re_o;
  end

  // Control registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      inflight_q <= inflight_d;
    end
  end

  assign done_o        = done_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign rdata_valid_o = (rbuf_count_s != 2'd0);
  assign rdata_o       = rbuf_head_s;

endmodule

// File: tb/tb_mem_burst_master.sv
module tb_mem_burst_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready_o;
  logic        cmd_we;
  logic [8:0]  cmd_addr;
  logic [7:0]  cmd_len;
  logic        wdata_valid;
  logic        wdata_ready_o;
  logic [15:0] wdata;
  logic        rdata_valid_o;
  logic        rdata_ready;
  logic [15:0] rdata_o;
  logic        done_o;
  logic        busy_o;
  logic        ram_re_o;
  logic        ram_we_o;
  logic [8:0]  ram_addr_o;
  logic [15:0] ram_wdata_o;
  logic [15:0] ram_rdata;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  int occ    = 0;
  logic        stall_prev = 1'b0;
  logic [15:0] stall_data = 16'h0000;
  logic        pop_now;

  logic [15:0] ram_mem [512];
  logic [15:0] exp_mem [512];
  logic [24:0] wq [$];
  logic [15:0] rq [$];

  always #5 clk = ~clk;

  mem_burst_master dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_we_i      (cmd_we),
    .cmd_addr_i    (cmd_addr),
    .cmd_len_i     (cmd_len),
    .wdata_valid_i (wdata_valid),
    .wdata_ready_o (wdata_ready_o),
    .wdata_i       (wdata),
    .rdata_valid_o (rdata_valid_o),
    .rdata_ready_i (rdata_ready),
    .rdata_o       (rdata_o),
    .done_o        (done_o),
    .busy_o        (busy_o),
    .ram_re_o      (ram_re_o),
    .ram_we_o      (ram_we_o),
    .ram_addr_o    (ram_addr_o),
    .ram_wdata_o   (ram_wdata_o),
    .ram_rdata_i   (ram_rdata)
  );

  // Single-port synchronous RAM with 1-cycle read latency.
  always @(posedge clk) begin
    if (ram_we_o) ram_mem[ram_addr_o] <= ram_wdata_o;
    if (ram_re_o) ram_rdata <= ram_mem[ram_addr_o];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      occ        = 0;
      stall_prev = 1'b0;
    end else begin
      pop_now = rdata_valid_o && rdata_ready;
      chk("strobe_excl", {31'd0, ram_re_o & ram_we_o}, 32'd0);
      if (ram_re_o) chk("issue_limit", {31'd0, (occ - int'(pop_now)) < 2}, 32'd1);
      if (ram_we_o) begin
        if (wq.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          logic [24:0] e;
          e = wq.pop_front();
          chk("write_addr", {23'd0, ram_addr_o}, {23'd0, e[24:16]});
          chk("write_data", {16'd0, ram_wdata_o}, {16'd0, e[15:0]});
        end
      end
      if (pop_now) begin
        if (rq.size() == 0) chk("unexpected_read", 32'd1, 32'd0);
        else chk("read_data", {16'd0, rdata_o}, {16'd0, rq.pop_front()});
        pops++;
      end
      if (stall_prev && rdata_valid_o) chk("stall_stable", {16'd0, rdata_o}, {16'd0, stall_data});
      stall_prev = rdata_valid_o && !rdata_ready;
      stall_data = rdata_o;
      occ = occ + int'(ram_re_o) - int'(pop_now);
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the handshake edge.
  task automatic send_cmd(input logic we, input logic [8:0] a, input logic [7:0] l);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = l;
    @(negedge clk);
    while (!cmd_ready_o && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("cmd_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [8:0] a, input logic [7:0] l,
                             input logic [15:0] base, input int gap_at);
    logic [8:0] ad;
    int n;
    for (int i = 0; i <= int'(l); i++) begin
      ad = a + 9'(i);
      wq.push_back({ad, base + 16'(i)});
      exp_mem[ad] = base + 16'(i);
    end
    send_cmd(1'b1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      if (i == gap_at) begin
        wdata_valid = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("gap_no_we", {31'd0, ram_we_o}, 32'd0);
          @(posedge clk); #1;
        end
      end
      wdata = base + 16'(i);
      wdata_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!wdata_ready_o && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) chk("wdata_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
    end
    wdata_valid = 1'b0;
    chk("write_done", {31'd0, done_o}, 32'd1);
    chk("write_done_ready", {31'd0, cmd_ready_o}, 32'd1);
    chk("write_wq_empty", wq.size(), 32'd0);
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0,1,0,0,...
  task automatic read_burst(input logic [8:0] a, input logic [7:0] l,
                            input int mode, input bit check_lat);
    int n;
    int cyc;
    logic [8:0] ad;
    for (int i = 0; i <= int'(l); i++) begin
      ad = a + 9'(i);
      rq.push_back(exp_mem[ad]);
    end
    rdata_ready = 1'b1;
    send_cmd(1'b0, a, l);
    if (check_lat) begin
      n = 0;
      @(negedge clk);
      while (!rdata_valid_o && n < 20) begin @(negedge clk); n++; end
      chk("read_latency", n, 32'd2);
    end
    cyc = 0;
    while (rq.size() > 0 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      rdata_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end
    chk("read_all_beats", rq.size(), 32'd0);
    rdata_ready = 1'b1;
    n = 0;
    while (!done_o && n < 10) begin @(negedge clk); n++; end
    chk("read_done", {31'd0, done_o}, 32'd1);
    chk("read_done_ready", {31'd0, cmd_ready_o}, 32'd1);
    @(posedge clk); #1;
    chk("done_pulse", {31'd0, done_o}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, {31'd0, cmd_ready_o}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    chk({tag, "_done"}, {31'd0, done_o}, 32'd0);
    chk({tag, "_wready"}, {31'd0, wdata_ready_o}, 32'd0);
    chk({tag, "_rvalid"}, {31'd0, rdata_valid_o}, 32'd0);
    chk({tag, "_re"}, {31'd0, ram_re_o}, 32'd0);
    chk({tag, "_we"}, {31'd0, ram_we_o}, 32'd0);
    chk({tag, "_addr"}, {23'd0, ram_addr_o}, 32'd0);
    chk({tag, "_wdata"}, {16'd0, ram_wdata_o}, 32'd0);
    chk({tag, "_rdata"}, {16'd0, rdata_o}, 32'd0);
  endtask

  initial begin
    int n;
    int p0;
    for (int i = 0; i < 512; i++) begin
      ram_mem[i] = 16'(i) ^ 16'h5A00;
      exp_mem[i] = 16'(i) ^ 16'h5A00;
    end
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 9'd0; cmd_len = 8'd0;
    wdata_valid = 1'b0; wdata = 16'h0000; rdata_ready = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic write then read-back with latency check.
    write_burst(9'h010, 8'd3, 16'hA001, -1);
    read_burst(9'h010, 8'd3, 0, 1'b1);

    // Address wrap.
    write_burst(9'h1FE, 8'd3, 16'hB001, -1);
    read_burst(9'h1FE, 8'd3, 0, 1'b1);

    // Backpressure over written and initial-content locations.
    read_burst(9'h010, 8'd7, 1, 1'b0);

    // Write stall mid-burst, then read back.
    write_burst(9'h040, 8'd5, 16'hC001, 2);
    read_burst(9'h040, 8'd5, 1, 1'b0);

    // Reset in the middle of a read burst.
    rq.delete();
    for (int i = 0; i < 8; i++) rq.push_back(exp_mem[9'h010 + 9'(i)]);
    rdata_ready = 1'b1;
    p0 = pops;
    send_cmd(1'b0, 9'h010, 8'd7);
    n = 0;
    while (pops < p0 + 2 && n < 30) begin @(posedge clk); #1; n++; end
    chk("midread_progress", {31'd0, pops >= p0 + 2}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    rq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_re", {31'd0, ram_re_o}, 32'd0);
    chk("release_we", {31'd0, ram_we_o}, 32'd0);
    @(posedge clk); #1;
    read_burst(9'h010, 8'd0, 0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("no_extra_beat", {31'd0, rdata_valid_o}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
